// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU = 0, serial loader = 1) in front of a single PSRAM port.
// Each transfer is one ISSUE strobe, then a bounded WAIT for ready_mem, then a one-cycle DONE.
module mem_arbiter #(
  parameter int unsigned TIMEOUT    = 1023,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a0,
  input  logic [31:0] d0,
  input  logic        we0,
  input  logic        rd0,
  output logic [31:0] spo0,
  output logic        ready0,
  input  logic [31:0] a1,
  input  logic [31:0] d1,
  input  logic        we1,
  input  logic        rd1,
  output logic [31:0] spo1,
  output logic        ready1,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            own_q, own_d;
  logic            last_q, last_d;
  logic            we_l_q, we_l_d;
  logic            rd_l_q, rd_l_d;
  logic [AW-1:0]   a_l_q, a_l_d;
  logic [DW-1:0]   d_l_q, d_l_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [DW-1:0]   spo0_q, spo0_d;
  logic [DW-1:0]   spo1_q, spo1_d;

  logic req0_c, req1_c, grant1_c, wait_done_c, timeout_c;

  assign req0_c   = we0 | rd0;
  assign req1_c   = we1 | rd1;
  // Loader wins a tie under fixed priority or when the CPU owned the port last.
  assign grant1_c = req1_c & (~req0_c | FIXED_PRIO | ~last_q);

  // The first WAIT cycle (cnt_q == 0) never completes; completion beats timeout.
  assign wait_done_c = (state_q == S_WAIT) && (cnt_q != '0) && ready_mem;
  assign timeout_c   = (state_q == S_WAIT) && !wait_done_c && (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      we_l_q  <= 1'b0;
      rd_l_q  <= 1'b0;
      a_l_q   <= '0;
      d_l_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      spo0_q  <= '0;
      spo1_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      we_l_q  <= we_l_d;
      rd_l_q  <= rd_l_d;
      a_l_q   <= a_l_d;
      d_l_q   <= d_l_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      spo0_q  <= spo0_d;
      spo1_q  <= spo1_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req0_c || req1_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_done_c || timeout_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latching, wait counter, read capture and sticky error
  always_comb begin
    own_d  = own_q;
    last_d = last_q;
    we_l_d = we_l_q;
    rd_l_d = rd_l_q;
    a_l_d  = a_l_q;
    d_l_d  = d_l_q;
    cnt_d  = '0;
    err_d  = err_q;
    spo0_d = spo0_q;
    spo1_d = spo1_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0_c || req1_c) begin
          own_d  = grant1_c;
          last_d = grant1_c;
          a_l_d  = grant1_c ? a1 : a0;
          d_l_d  = grant1_c ? d1 : d0;
          we_l_d = grant1_c ? we1 : we0;
          rd_l_d = ~(grant1_c ? we1 : we0) & (grant1_c ? rd1 : rd0);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (wait_done_c && rd_l_q) begin
          if (own_q) spo1_d = spo_mem;
          else       spo0_d = spo_mem;
        end
      end
      default: ;
    endcase
    if (timeout_c)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Output decode
  always_comb begin
    a_mem  = '0;
    d_mem  = '0;
    we_mem = 1'b0;
    rd_mem = 1'b0;
    if (state_q != S_IDLE) begin
      a_mem = a_l_q;
      d_mem = d_l_q;
    end
    if (state_q == S_ISSUE) begin
      we_mem = we_l_q;
      rd_mem = rd_l_q;
    end
    ready0 = ~req0_c | ((state_q == S_DONE) && !own_q);
    ready1 = ~req1_c | ((state_q == S_DONE) && own_q);
  end

  assign spo0        = spo0_q;
  assign spo1        = spo1_q;
  assign timeout_err = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, the maximum WAIT cycles before abort (1..65535).
REQ-002 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = requester 1 (loader) always wins.
REQ-003 SHALL have ports: clk input 1, system clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have ports a0/d0 input 32/32, we0/rd0 input 1/1, spo0 output 32, ready0 output 1: requester 0 (CPU).
REQ-005 SHALL have ports a1/d1 input 32/32, we1/rd1 input 1/1, spo1 output 32, ready1 output 1: requester 1 (serial loader).
REQ-006 SHALL have ports a_mem/d_mem output 32/32, we_mem/rd_mem output 1/1, spo_mem input 32, ready_mem input 1: the shared PSRAM port.
REQ-007 SHALL have ports timeout_err output 1 (sticky abort flag) and err_clr input 1 (clears it).

Function
REQ-008 SHALL define req_n = we_n | rd_n, level-held by requester n until it samples ready_n = 1; we_n has priority over rd_n if both are set.
REQ-009 SHALL implement the states IDLE, ISSUE, WAIT and DONE, with owner register own (0/1).
REQ-010 IDLE: if any req_n is set, SHALL select the owner, latch a, d and we/rd of that requester, and go to ISSUE next cycle.
REQ-011 Round-robin: if both requests are set, SHALL grant the requester that was not the last owner; last owner resets to 1, so the CPU wins the first tie.
REQ-012 ISSUE: SHALL drive we_mem or rd_mem high for exactly this one cycle, with a_mem/d_mem from the latched values, then go to WAIT.
REQ-013 a_mem/d_mem SHALL stay at the latched values from ISSUE through DONE; in IDLE they SHALL be 0, and we_mem/rd_mem SHALL be 0 in every state except ISSUE.
REQ-014 WAIT: SHALL ignore ready_mem in the first WAIT cycle; from the second WAIT cycle on, ready_mem = 1 SHALL capture spo_mem into the owner's spo register and go to DONE.
REQ-015 DONE: ready_own SHALL be 1 for this one cycle, then the block SHALL return to IDLE; a request still held in IDLE is treated as a new transaction.
REQ-016 ready_n SHALL be 1 when req_n = 0, or when in DONE with own = n; otherwise 0. A requester that requests while the other owns the port SHALL therefore see ready low until its own DONE.
REQ-017 spo_n SHALL hold its last captured value until the next read completes for n; write completions SHALL leave spo_n unchanged.
REQ-018 WAIT SHALL count with a 16-bit counter; reaching TIMEOUT cycles without completion SHALL set timeout_err, go to DONE (spo unchanged) and release the owner.
REQ-019 err_clr SHALL clear timeout_err; if a timeout and err_clr happen in the same cycle, the set SHALL win.
REQ-020 Requests and deassertions by a non-owner during ISSUE/WAIT/DONE SHALL NOT affect the transfer in flight; an owner that drops its request mid-transfer SHALL NOT abort it.
REQ-021 Minimum latency SHALL be 4 cycles, from req sampled in IDLE to ready in DONE, when ready_mem is already high.

Reset
REQ-022 rst SHALL force IDLE, last owner = 1, counter 0, timeout_err 0, spo0 = spo1 = 0, we_mem = rd_mem = 0 and a_mem = d_mem = 0, on the next clock edge, including mid-transfer.
REQ-023 A transfer cut by reset SHALL NOT be resumed; requests still held after reset SHALL be treated as new.

Verification
REQ-024 CPU rd0 at a0 = 0x100, memory returns 0xDEADBEEF with ready_mem high -> rd_mem is a one-cycle pulse with a_mem = 0x100, ready0 = 1 four cycles after the request, spo0 = 0xDEADBEEF.
REQ-025 we0 and we1 asserted in the same cycle, FIXED_PRIO = 0, after reset -> CPU is served first, then the loader; ready1 stays 0 until the loader's DONE.
REQ-026 Same stimulus with FIXED_PRIO = 1 -> loader is served first; four back-to-back loader writes at 0x0, 0x4, 0x8, 0xC starve the CPU until the loader's requests stop.
REQ-027 TIMEOUT = 8 with ready_mem held 0 -> timeout_err = 1 after 8 WAIT cycles, the owner gets ready, the other requester is then granted; err_clr clears the flag.
REQ-028 rst asserted in the third WAIT cycle of a loader write -> next cycle IDLE with all outputs 0; the held we1 restarts the transfer with a fresh ISSUE pulse.
